// File: rtl/reg_writeback_scheduler_if.sv
// Write-back port bundle: ALU result, load-result handshake, register-file write port and status.
interface reg_writeback_scheduler_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           alu_valid;
    logic [4:0]     alu_addr;
    logic [N-1:0]   alu_data;
    logic           ld_valid;
    logic           ld_ready;
    logic [4:0]     ld_addr;
    logic [N-1:0]   ld_data;
    logic           WE3;
    logic [4:0]     A3;
    logic [N-1:0]   WD3;
    logic [15:0]    pend_mask;
    logic [CW-1:0]  fifo_count;
    logic [7:0]     drop_cnt;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  ld_ready, WE3, A3, WD3, pend_mask, fifo_count, drop_cnt
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output ld_ready, WE3, A3, WD3, pend_mask, fifo_count, drop_cnt
    );
endinterface

// File: rtl/reg_writeback_scheduler.sv
// Merges ALU results and buffered load results onto a single register-file write port.
// ALU results always win; queued loads that an ALU write overtakes are squashed in place.
module reg_writeback_scheduler #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    reg_writeback_scheduler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [4:0]       ent_addr_q [DEPTH];
    logic [N-1:0]     ent_data_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       a3_q, a3_d;
    logic [N-1:0]     wd3_q, wd3_d;
    logic [7:0]       drop_q, drop_d;

    logic       alu_legal, ld_acc, ld_ok, fifo_empty;
    logic       push, pop, bypass;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;
    logic [15:0] pend;

    // Register 0 is hard zero and register 15 is the PC; bit 4 selects a non-scalar file.
    function automatic logic legal(input logic [4:0] a);
        return !a[4] && (a[3:0] != 4'd0) && (a[3:0] != 4'd15);
    endfunction

    assign bus.ld_ready = rst && (count_q < CW'(DEPTH));
    assign alu_legal    = bus.alu_valid && legal(bus.alu_addr);
    assign ld_acc       = bus.ld_valid && bus.ld_ready;
    assign ld_ok        = ld_acc && legal(bus.ld_addr);
    assign fifo_empty   = (count_q == '0);

    always_comb begin
        we_d      = 1'b0;
        a3_d      = a3_q;
        wd3_d     = wd3_q;
        ent_vld_d = ent_vld_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pop       = 1'b0;
        bypass    = 1'b0;
        push      = 1'b0;

        if (alu_legal) begin
            we_d  = 1'b1;
            a3_d  = bus.alu_addr;
            wd3_d = bus.alu_data;
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld_q[i] && (ent_addr_q[i] == bus.alu_addr)) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end else if (!fifo_empty) begin
            pop = 1'b1;
            if (ent_vld_q[rd_ptr_q]) begin
                we_d  = 1'b1;
                a3_d  = ent_addr_q[rd_ptr_q];
                wd3_d = ent_data_q[rd_ptr_q];
            end
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (ld_ok) begin
            bypass = 1'b1;
            we_d   = 1'b1;
            a3_d   = bus.ld_addr;
            wd3_d  = bus.ld_data;
        end

        // A load to the same register as the concurrent ALU result is already stale.
        push = ld_ok && !bypass && !(alu_legal && (bus.ld_addr == bus.alu_addr));
        if (push) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        count_d = count_q + CW'(push) - CW'(pop);

        drop_inc = 2'(bus.alu_valid && !legal(bus.alu_addr))
                 + 2'(ld_acc && !legal(bus.ld_addr));
        drop_sum = {1'b0, drop_q} + 9'(drop_inc);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            a3_q      <= '0;
            wd3_q     <= '0;
            drop_q    <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            a3_q      <= a3_d;
            wd3_q     <= wd3_d;
            drop_q    <= drop_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= bus.ld_addr;
            ent_data_q[wr_ptr_q] <= bus.ld_data;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i]) begin
                pend[ent_addr_q[i][3:0]] = 1'b1;
            end
        end
        if (we_q) begin
            pend[a3_q[3:0]] = 1'b1;
        end
    end

    assign bus.WE3        = we_q;
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd3_q;
    assign bus.pend_mask  = pend;
    assign bus.fifo_count = count_q;
    assign bus.drop_cnt   = drop_q;
endmodule
